// File: rtl/conv1d_seq.sv
// conv1d_seq: sequencer/datapath for one valid-mode 1-D convolution over a request/grant SRAM port.
// Latency: first req_o one cycle after start_i; zero-wait run ends with done_o at M*(4K+2)+1 cycles.
// Backpressure: one outstanding access; REQ states hold addr/we/wdata until gnt_i, WAIT states hold until rvalid_i.
// Ports: clk_i/rst_i (async active-high), start_i/abort_i control, len_i/klen_i/x_base_i/w_base_i/y_base_i/shift_i
//        config (latched on start), req_o/we_o/addr_o/wdata_o/gnt_i/rvalid_i/rdata_i memory port,
//        busy_o/done_o/err_o status.
module conv1d_seq #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MAX_LEN = 256,
    parameter int MAX_K   = 16,
    parameter int ACC_W   = 40
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [$clog2(MAX_LEN):0]  len_i,
    input  logic [$clog2(MAX_K):0]    klen_i,
    input  logic [ADDR_W-1:0]         x_base_i,
    input  logic [ADDR_W-1:0]         w_base_i,
    input  logic [ADDR_W-1:0]         y_base_i,
    input  logic [3:0]                shift_i,
    output logic                      req_o,
    output logic                      we_o,
    output logic [ADDR_W-1:0]         addr_o,
    output logic [DATA_W-1:0]         wdata_o,
    input  logic                      gnt_i,
    input  logic                      rvalid_i,
    input  logic [DATA_W-1:0]         rdata_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o
);
    localparam int LEN_W  = $clog2(MAX_LEN) + 1;
    localparam int KL_W   = $clog2(MAX_K) + 1;
    localparam int PROD_W = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, RDX_REQ, RDX_WAIT, RDW_REQ, RDW_WAIT, WR_REQ, WR_WAIT, DONE
    } state_t;

    state_t                    state_q;
    logic [KL_W-1:0]           klen_q, k_q;
    logic [LEN_W-1:0]          m_q, o_q;
    logic [ADDR_W-1:0]         x_base_q, w_base_q, y_base_q;
    logic [3:0]                shift_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [DATA_W-1:0]  xval_q;
    logic                      abort_pend_q;
    logic                      req_q, we_q, busy_q, done_q, err_q;
    logic [ADDR_W-1:0]         addr_q;
    logic [DATA_W-1:0]         wdata_q;

    logic signed [PROD_W-1:0]  prod_d;
    logic signed [ACC_W-1:0]   acc_d, shifted_d;
    logic [DATA_W-1:0]         ysat_d;
    logic                      cfg_bad_d, stop_d, last_tap_d, last_out_d;
    logic [LEN_W-1:0]          m_d;
    logic [ADDR_W-1:0]         xa_next_tap_d, xa_next_out_d, wa_d, ya_d;

    function automatic state_t wait_of(input state_t s);
        case (s)
            RDX_REQ: return RDX_WAIT;
            RDW_REQ: return RDW_WAIT;
            default: return WR_WAIT;
        endcase
    endfunction

    always_comb begin
        prod_d = xval_q * $signed(rdata_i);
        // k==0 starts a fresh sum, so the clear and the first MAC share one cycle
        acc_d = ((k_q == '0) ? '0 : acc_q) + {{(ACC_W-PROD_W){prod_d[PROD_W-1]}}, prod_d};
        shifted_d = acc_d >>> shift_q;
        if (shifted_d > SAT_MAX) begin
            ysat_d = SAT_MAX[DATA_W-1:0];
        end else if (shifted_d < SAT_MIN) begin
            ysat_d = SAT_MIN[DATA_W-1:0];
        end else begin
            ysat_d = shifted_d[DATA_W-1:0];
        end
        cfg_bad_d = (len_i == '0) || (klen_i == '0) || (LEN_W'(klen_i) > len_i) ||
                    (len_i > LEN_W'(MAX_LEN)) || (klen_i > KL_W'(MAX_K));
        m_d = len_i - LEN_W'(klen_i) + LEN_W'(1);
        // an abort seen earlier in this transaction only takes effect once its response lands
        stop_d = abort_i || abort_pend_q;
        last_tap_d = (k_q == klen_q - KL_W'(1));
        last_out_d = (o_q == m_q - LEN_W'(1));
        xa_next_tap_d = x_base_q + ADDR_W'(o_q) + ADDR_W'(k_q) + ADDR_W'(1);
        xa_next_out_d = x_base_q + ADDR_W'(o_q) + ADDR_W'(1);
        wa_d = w_base_q + ADDR_W'(k_q);
        ya_d = y_base_q + ADDR_W'(o_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            klen_q <= '0; k_q <= '0; m_q <= '0; o_q <= '0;
            x_base_q <= '0; w_base_q <= '0; y_base_q <= '0; shift_q <= '0;
            acc_q <= '0; xval_q <= '0; abort_pend_q <= 1'b0;
            req_q <= 1'b0; we_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
            addr_q <= '0; wdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        klen_q <= klen_i; m_q <= m_d; shift_q <= shift_i;
                        x_base_q <= x_base_i; w_base_q <= w_base_i; y_base_q <= y_base_i;
                        o_q <= '0; k_q <= '0; acc_q <= '0; abort_pend_q <= 1'b0;
                        if (cfg_bad_d) begin
                            state_q <= DONE; done_q <= 1'b1; err_q <= 1'b1;
                        end else begin
                            state_q <= RDX_REQ; req_q <= 1'b1; we_q <= 1'b0;
                            addr_q <= x_base_i; busy_q <= 1'b1; err_q <= 1'b0;
                        end
                    end
                end
                RDX_REQ, RDW_REQ, WR_REQ: begin
                    if (gnt_i) begin
                        state_q <= wait_of(state_q); req_q <= 1'b0; we_q <= 1'b0;
                        abort_pend_q <= abort_i;
                    end else if (abort_i) begin
                        state_q <= DONE; req_q <= 1'b0; we_q <= 1'b0;
                        busy_q <= 1'b0; done_q <= 1'b1; err_q <= 1'b1;
                    end
                end
                RDX_WAIT, RDW_WAIT, WR_WAIT: begin
                    if (rvalid_i) begin
                        if (state_q == RDW_WAIT) acc_q <= acc_d;
                        if (stop_d) begin
                            state_q <= DONE; busy_q <= 1'b0; done_q <= 1'b1; err_q <= 1'b1;
                        end else if (state_q == RDX_WAIT) begin
                            xval_q <= $signed(rdata_i);
                            state_q <= RDW_REQ; req_q <= 1'b1; addr_q <= wa_d;
                        end else if (state_q == RDW_WAIT) begin
                            req_q <= 1'b1;
                            if (last_tap_d) begin
                                k_q <= '0; state_q <= WR_REQ; we_q <= 1'b1;
                                addr_q <= ya_d; wdata_q <= ysat_d;
                            end else begin
                                k_q <= k_q + KL_W'(1); state_q <= RDX_REQ; addr_q <= xa_next_tap_d;
                            end
                        end else if (last_out_d) begin
                            state_q <= DONE; busy_q <= 1'b0; done_q <= 1'b1;
                        end else begin
                            o_q <= o_q + LEN_W'(1); state_q <= RDX_REQ; req_q <= 1'b1;
                            addr_q <= xa_next_out_d;
                        end
                    end else if (abort_i) begin
                        abort_pend_q <= 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_o   = req_q;
    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
endmodule

// File: doc/conv1d_seq.md
# conv1d_seq

Sequencer and datapath controller for the conv1d accelerator. It runs one valid-mode 1-D convolution over word-addressed accelerator SRAM: it fetches input samples and kernel taps over a single request/grant memory port, accumulates products, then writes back scaled, saturated outputs. It sits between the conv1d control-register block (start, lengths, base addresses, shift) and the accelerator SRAM port, and raises the done interrupt.

## Interface
- ADDR_W, 16, word address width
- DATA_W, 16, signed sample/tap/output width
- MAX_LEN, 256, maximum input length N
- MAX_K, 16, maximum kernel length K
- ACC_W, 40, signed accumulator width (≥ 2·DATA_W + clog2(MAX_K))

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  start pulse; sampled only in IDLE
- abort_i  in  1  abort request
- len_i  in  clog2(MAX_LEN)+1  N
- klen_i  in  clog2(MAX_K)+1  K
- x_base_i / w_base_i / y_base_i  in  ADDR_W  base addresses of input, kernel, output
- shift_i  in  4  output right-shift
- req_o  out  1  memory request
- we_o  out  1  1 = write
- addr_o  out  ADDR_W  word address
- wdata_o  out  DATA_W  write data
- gnt_i  in  1  request accepted
- rvalid_i  in  1  response valid (reads and writes)
- rdata_i  in  DATA_W  read data
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle completion pulse (interrupt)
- err_o  out  1  last run failed or was aborted; cleared on the next accepted start

## Operation
- Reset: all outputs 0. State IDLE, counters and accumulator 0.
- In IDLE, start_i latches all config inputs. Later changes to config inputs have no effect on the run.
- Config check on start: K=0, N=0, K>N, N>MAX_LEN, or K>MAX_K → go to DONE with err_o=1. No memory access is made.
- Otherwise M = N−K+1 outputs. For o in 0..M−1 and k in 0..K−1:
  - acc cleared when k=0
  - read x[x_base+o+k], then read w[w_base+k]
  - acc += x·w, signed full precision, sign-extended to ACC_W
  - after the last tap, write y[y_base+o]
- Output arithmetic: acc >>> shift_i (arithmetic shift, truncation toward −∞), then saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Address arithmetic is modulo 2^ADDR_W (wraps).
- States: IDLE, RDX_REQ, RDX_WAIT, RDW_REQ, RDW_WAIT, WR_REQ, WR_WAIT, DONE.
  - REQ states: req_o=1; addr/we/wdata held stable until gnt_i. On gnt_i, move to the matching WAIT state.
  - WAIT states: req_o=0. Advance on rvalid_i.
  - In RDW_WAIT, rvalid_i also performs the MAC.
  - DONE: done_o=1 for one cycle, then IDLE.
- One outstanding transaction at most. rvalid_i outside WAIT states is ignored.
- abort_i while busy:
  - In a REQ state without gnt_i that cycle: drop req_o next cycle and go to DONE.
  - If gnt_i coincides with abort_i, or the state is a WAIT state: wait for rvalid_i, then go to DONE.
  - err_o=1 in all abort cases. abort_i in IDLE or DONE is ignored. start_i and abort_i together in IDLE: start wins.
- busy_o=1 in every state except IDLE and DONE.

## Timing
- start_i sampled at cycle 0 → first req_o at cycle 1.
- With gnt_i tied high and rvalid_i exactly one cycle after grant: each tap takes 4 cycles, each write 2 cycles. done_o is high at cycle M·(4K+2)+1.
- Config error: done_o is high at cycle 1.
- Grant/response stalls add cycles one-for-one and do not change results.
- Reset mid-run: req_o, busy_o, done_o drop immediately (asynchronous). An outstanding response arriving after reset is ignored.

## Test plan
- N=4, K=2, x=[1,2,3,4], w=[1,1], shift 0, zero-wait memory → writes y=[3,5,7] to y_base..y_base+2; done_o at cycle 31; err_o=0.
- Saturation: N=2, K=2, x=w=[32767,32767] → y=32767. x=[−32768,−32768], w=[32767,32767] → y=−32768.
- Shift/rounding: K=1, w=[1], x=[7,−7], shift 1 → y=[3,−4].
- Config error: N=4, K=5 → no req_o; done_o at cycle 1; err_o=1. A following valid start clears err_o.
- Backpressure: rerun the first case with random gnt_i stalls and 0–3 cycle rvalid delays → identical y; addr_o and we_o stable during every stall.
- Abort and reset: abort_i asserted during RDX_WAIT → completes that response, done_o, err_o=1, no further requests. rst_i asserted mid-write → all outputs 0 immediately; FSM in IDLE after release.
